// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and stall-priority helper for the
// pipeline controller.
package pipe_ctrl_pkg;

  // Stall vector layout: one hold bit per pipeline register.
  localparam int STALL_W  = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Precomputed stall patterns: everything upstream of the requester holds.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_BY_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_BY_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_BY_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_BY_MEM = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL    = 6'b111111;

  // Exception codes delivered from MEM.
  localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_EXC_FLUSH = 1'b1
  } state_e;

  // Deepest requesting stage wins since it must also hold everything before it.
  function automatic logic [STALL_W-1:0] stall_from_req(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [STALL_W-1:0] pat;
    if (req_mem == STOP) begin
      pat = STALL_BY_MEM;
    end else if (req_ex == STOP) begin
      pat = STALL_BY_EX;
    end else if (req_id == STOP) begin
      pat = STALL_BY_ID;
    end else if (req_if == STOP) begin
      pat = STALL_BY_IF;
    end else begin
      pat = STALL_NONE;
    end
    return pat;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive frozen cycles and raises a sticky flag once the
// pipeline has stayed frozen for MAX_STALL cycles.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled_i,
  output logic stall_timeout_o
);

  localparam logic [15:0] LIMIT = 16'(MAX_STALL);

  logic [15:0] count_q, count_d;
  logic        timeout_q, timeout_d;

  // Saturating run-length counter; flag sets the cycle the count hits LIMIT.
  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (stalled_i) begin
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = 16'd0;
    end
    if (count_d >= LIMIT) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_q   <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences the
// exception/eret freeze-then-flush redirect, and hosts the stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_BASE  = 32'h0000_0020,
  parameter int unsigned MAX_STALL = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;

  // State and redirect-target registers; reset abandons any pending flush.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= ST_RUN;
      new_pc_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state; the target is captured only on the exception cycle so
  // later EPC changes or stray exceptions in the flush cycle cannot alter it.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (excepttype_i != EXC_NONE) begin
          state_d = ST_EXC_FLUSH;
          if (excepttype_i == EXC_ERET) begin
            new_pc_d = cp0_epc_i;
          end else begin
            new_pc_d = EXC_BASE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EXC_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Outputs: freeze everything on the exception cycle, then flush with no
  // stall so the redirect is loaded cleanly; reset silences both.
  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (rst == RstEnable) begin
      stall = STALL_NONE;
      flush = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          flush = 1'b0;
          if (excepttype_i != EXC_NONE) begin
            stall = STALL_ALL;
          end else begin
            stall = stall_from_req(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
          end
        end
        ST_EXC_FLUSH: begin
          stall = STALL_NONE;
          flush = 1'b1;
        end
        default: begin
          stall = STALL_NONE;
          flush = 1'b0;
        end
      endcase
    end
  end

  assign new_pc = new_pc_q;

  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .stalled_i      (stall != STALL_NONE),
    .stall_timeout_o(stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (watchdog limit set to 4).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(
    .EXC_BASE (32'h0000_0020),
    .MAX_STALL(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sf(input string tag, input logic [5:0] exp_stall, input logic exp_flush);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, exp_stall});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
  endtask

  // Move to the low phase of the next cycle; inputs change here.
  task automatic next_cyc;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0;

    // Reset forces outputs low even with requests present.
    next_cyc(); stallreq_mem = 1'b1; excepttype_i = 32'h8; settle();
    chk_sf("rst_forced", 6'b000000, 1'b0);
    next_cyc(); rst = 1'b0; stallreq_mem = 1'b0; excepttype_i = 32'h0; settle();
    chk_sf("after_rst", 6'b000000, 1'b0);
    chk("after_rst.new_pc", new_pc, 32'h0);
    chk("after_rst.timeout", {31'd0, stall_timeout}, 32'd0);

    // Stall priority, zero-cycle response.
    next_cyc(); stallreq_id = 1'b1; stallreq_mem = 1'b1; settle();
    chk_sf("prio_id_mem", 6'b011111, 1'b0);
    stallreq_mem = 1'b0; settle();
    chk_sf("prio_drop_mem", 6'b000111, 1'b0);
    next_cyc(); stallreq_id = 1'b0; stallreq_ex = 1'b1; stallreq_if = 1'b1; settle();
    chk_sf("prio_ex_if", 6'b001111, 1'b0);
    stallreq_ex = 1'b0; settle();
    chk_sf("prio_if", 6'b000011, 1'b0);
    next_cyc(); stallreq_if = 1'b0; settle();
    chk_sf("prio_none", 6'b000000, 1'b0);

    // Syscall: freeze, flush to EXC_BASE, resume.
    next_cyc(); excepttype_i = 32'h8; settle();
    chk_sf("sys_N", 6'b111111, 1'b0);
    next_cyc(); excepttype_i = 32'h0; settle();
    chk_sf("sys_N1", 6'b000000, 1'b1);
    chk("sys_N1.new_pc", new_pc, 32'h0000_0020);
    next_cyc(); settle();
    chk_sf("sys_N2", 6'b000000, 1'b0);
    chk("sys_N2.new_pc_hold", new_pc, 32'h0000_0020);

    // Eret: redirect to EPC sampled on the exception cycle only.
    next_cyc(); cp0_epc_i = 32'h0000_1234; excepttype_i = 32'he; settle();
    chk_sf("eret_N", 6'b111111, 1'b0);
    next_cyc(); excepttype_i = 32'h0; cp0_epc_i = 32'h0000_5678; settle();
    chk_sf("eret_N1", 6'b000000, 1'b1);
    chk("eret_N1.new_pc", new_pc, 32'h0000_1234);
    next_cyc(); settle();
    chk("eret_N2.new_pc", new_pc, 32'h0000_1234);
    chk_sf("eret_N2", 6'b000000, 1'b0);

    // Flush overrides a held EX request; exception in N+1 is ignored.
    next_cyc(); stallreq_ex = 1'b1; excepttype_i = 32'h8; settle();
    chk_sf("ovr_N", 6'b111111, 1'b0);
    next_cyc(); excepttype_i = 32'he; cp0_epc_i = 32'h0000_9999; settle();
    chk_sf("ovr_N1", 6'b000000, 1'b1);
    chk("ovr_N1.new_pc", new_pc, 32'h0000_0020);
    next_cyc(); excepttype_i = 32'h0; settle();
    chk_sf("ovr_N2", 6'b001111, 1'b0);
    chk("ovr_N2.new_pc", new_pc, 32'h0000_0020);

    // Exception held through N+2 is taken again as a new one (eret this time).
    next_cyc(); stallreq_ex = 1'b0; excepttype_i = 32'h8; settle();
    chk_sf("b2b_N", 6'b111111, 1'b0);
    next_cyc(); settle();
    chk_sf("b2b_N1", 6'b000000, 1'b1);
    next_cyc(); excepttype_i = 32'he; cp0_epc_i = 32'h0000_4444; settle();
    chk_sf("b2b_N2", 6'b111111, 1'b0);
    next_cyc(); excepttype_i = 32'h0; settle();
    chk_sf("b2b_N3", 6'b000000, 1'b1);
    chk("b2b_N3.new_pc", new_pc, 32'h0000_4444);
    next_cyc(); settle();
    chk_sf("b2b_N4", 6'b000000, 1'b0);

    // Watchdog: fresh reset, then IF stall with one gap that clears the count.
    next_cyc(); rst = 1'b1; settle();
    next_cyc(); rst = 1'b0; stallreq_if = 1'b1; settle();
    chk("wd_start", {31'd0, stall_timeout}, 32'd0);
    next_cyc(); next_cyc(); next_cyc(); settle();
    chk("wd_cnt3", {31'd0, stall_timeout}, 32'd0);
    stallreq_if = 1'b0;
    next_cyc(); stallreq_if = 1'b1; settle();
    chk("wd_gap_clear", {31'd0, stall_timeout}, 32'd0);
    next_cyc(); next_cyc(); next_cyc(); settle();
    chk("wd_cnt3_again", {31'd0, stall_timeout}, 32'd0);
    next_cyc(); settle();
    chk("wd_cnt4_trip", {31'd0, stall_timeout}, 32'd1);
    stallreq_if = 1'b0;
    next_cyc(); next_cyc(); settle();
    chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
    chk_sf("wd_released", 6'b000000, 1'b0);
    rst = 1'b1;
    next_cyc(); rst = 1'b0; settle();
    chk("wd_rst_clear", {31'd0, stall_timeout}, 32'd0);

    // Reset in the flush cycle aborts the flush and clears the target.
    next_cyc(); excepttype_i = 32'h8; settle();
    chk_sf("rflush_N", 6'b111111, 1'b0);
    next_cyc(); excepttype_i = 32'h0; rst = 1'b1; settle();
    chk_sf("rflush_N1_rst", 6'b000000, 1'b0);
    next_cyc(); rst = 1'b0; settle();
    chk_sf("rflush_after", 6'b000000, 1'b0);
    chk("rflush_after.new_pc", new_pc, 32'h0);
    next_cyc(); stallreq_id = 1'b1; settle();
    chk_sf("rflush_run", 6'b000111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It merges stall requests from the IF, ID, EX and MEM stages into the 6-bit `stall` vector consumed by the PC register and every inter-stage register. It also sequences exception and `eret` redirection: it freezes the pipe for one cycle, then pulses `flush` with the redirect PC. A stall watchdog flags a pipeline that stays frozen for too long.

## Interface
- `EXC_BASE`, default 32'h0000_0020: redirect PC for every exception except `eret`.
- `MAX_STALL`, default 255: consecutive stalled cycles allowed before the timeout flag sets; range 1..65535.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stallreq_if` in 1: instruction fetch not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle EX operation busy.
- `stallreq_mem` in 1: data bus wait.
- `excepttype_i` in 32: exception code from MEM; 0 means none.
- `cp0_epc_i` in 32: current CP0 EPC.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- `flush` out 1: clear all inter-stage registers and load `new_pc`.
- `new_pc` out 32: redirect target, valid only while `flush`=1.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- Two-state FSM: RUN and EXC_FLUSH.
- **RUN, `excepttype_i`=0:** `stall` comes from the deepest asserted request. `flush`=0.
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- **RUN, `excepttype_i`≠0:** `stall`=6'b111111 this cycle, overriding all requests.
  - Latch the redirect target: `cp0_epc_i` if code is 32'h0000_000e (`eret`), else `EXC_BASE`.
  - Next state is EXC_FLUSH.
- **EXC_FLUSH:**
  - `flush`=1, `new_pc`=latched target, `stall`=6'b000000.
  - All stall requests and `excepttype_i` are ignored.
  - Next state is RUN unconditionally.
- **Outside a flush:** `new_pc` holds its last value.
- **Watchdog:**
  - A 16-bit counter increments each cycle `stall`≠0 and clears on any cycle `stall`=0.
  - When the counter reaches `MAX_STALL`, `stall_timeout` sets and stays 1 until `rst`.
  - The counter saturates at 16'hFFFF.
- Stall requests arriving together with an exception do not affect the latched target.

## Timing
- `stall` is combinational from state and requests: zero-cycle latency, same cycle as the request.
- Exception seen in cycle N:
  - cycle N: `stall`=6'b111111
  - cycle N+1: `flush`=1
  - cycle N+2: back in RUN
- Back-to-back exceptions: an exception present in N+1 is ignored. If it is still present in N+2, it is handled as new.
- Reset values (the cycle after `rst` is sampled high): state RUN, `stall`=0, `flush`=0, `new_pc`=0, counter 0, `stall_timeout`=0.
  - While `rst`=1, `stall` and `flush` are forced to 0.
- Reset during EXC_FLUSH aborts the flush: no `flush` pulse follows reset.
- `flush` is never asserted in the same cycle as any `stall` bit.

## Structure
- Shared package holds:
  - stall-bit indices and `STOP`/`NO_STOP`
  - `RstEnable`, `ZeroWord`
  - exception code constants, including ERET = 32'h0000_000e
  - FSM state encoding
- Sub-module `stall_watchdog` holds the counter and sticky flag, parameterised by `MAX_STALL`.
- Everything else lives in a single `pipe_ctrl` body.

## Test plan
- **Priority:** `stallreq_id`=1 and `stallreq_mem`=1 together → `stall`=6'b011111. Drop `stallreq_mem` → 6'b000111 in the same cycle.
- **Syscall:** `excepttype_i`=32'h8 for one cycle →
  - cycle N: `stall`=6'b111111, `flush`=0
  - cycle N+1: `flush`=1, `new_pc`=32'h0000_0020, `stall`=0
  - cycle N+2: `flush`=0
- **Eret:** `cp0_epc_i`=32'h0000_1234, `excepttype_i`=32'he → `new_pc`=32'h0000_1234 during the flush cycle. Changing EPC during the flush cycle has no effect.
- **Flush overrides stall:** `stallreq_ex` held at 1 through an exception → `stall`=0 in the flush cycle and 6'b001111 again afterwards.
- **Watchdog:** `MAX_STALL`=4, `stallreq_if` held at 1 →
  - `stall_timeout` rises on the cycle the counter reaches 4
  - releasing the request leaves it at 1
  - `rst` clears it
- **Reset mid-flush:** `rst`=1 in the EXC_FLUSH cycle → next cycle `flush`=0, `stall`=0, `new_pc`=0, state RUN.
